// File: rtl/spi_sram_target_if.sv
// SPI pin bundle between an SPI master and the spi_sram_target responder.
// The master drives select, clock and data out; the target returns miso and an active flag.
interface spi_sram_target_if;
  logic spi_cs_n;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic active;

  modport master (output spi_cs_n, spi_clk, spi_mosi, input spi_miso, active);
  modport slave  (input spi_cs_n, spi_clk, spi_mosi, output spi_miso, active);
endinterface

// File: rtl/spi_sram_target.sv
// SPI mode-0 serial SRAM emulator (READ 0x03 / WRITE 0x02, 16-bit address, auto-increment).
// Optional JEDEC-style ID read (opcode 0x9F) is enabled by defining SPI_SRAM_RDID_EN.
module spi_sram_target #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_sram_target_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ, S_WRITE, S_IGNORE, S_RDID
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   sclk_hist;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             addr_hi;
  logic [ADDR_W-1:0]      addr;
  logic                   is_write;
  logic                   miso_q;
  logic [7:0]             mem [DEPTH];
`ifdef SPI_SRAM_RDID_EN
  logic [1:0]             id_idx;
  logic [7:0]             id_byte;
`endif

  // Oversampled SPI pins; cs_n resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic              cs_s, sclk_s, mosi_s, rise, fall, deselect, byte_done, shifting, mem_we;
  logic [7:0]        rx_next;
  logic [ADDR_W-1:0] addr_full, addr_inc, mem_raddr;
  logic [7:0]        mem_rdata;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_hist;
  assign fall      = ~sclk_s & sclk_hist;
  assign deselect  = cs_s && (state != S_IDLE);
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx_shift, mosi_s};
  assign addr_full = ADDR_W'({addr_hi, rx_next});
  assign addr_inc  = addr + ADDR_W'(1);
  assign shifting  = (state == S_READ) || (state == S_RDID);
  assign mem_we    = (state == S_WRITE) && byte_done && !cs_s;
  // First read comes from the just-assembled address; later ones from the incremented one.
  assign mem_raddr = (state == S_ADDR_LO) ? addr_full : addr_inc;
  assign mem_rdata = mem[mem_raddr];

`ifdef SPI_SRAM_RDID_EN
  always_comb begin
    case (id_idx)
      2'd0:    id_byte = 8'hD5;
      2'd1:    id_byte = 8'hC0;
      default: id_byte = 8'(ADDR_W);
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (deselect) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (!cs_s) next_state = S_CMD;
        S_CMD:
          if (byte_done) begin
            case (rx_next)
              8'h02, 8'h03: next_state = S_ADDR_HI;
`ifdef SPI_SRAM_RDID_EN
              8'h9F:        next_state = S_RDID;
`endif
              default:      next_state = S_IGNORE;
            endcase
          end
        S_ADDR_HI: if (byte_done) next_state = S_ADDR_LO;
        S_ADDR_LO: if (byte_done) next_state = is_write ? S_WRITE : S_READ;
        default:   next_state = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      addr_hi  <= '0;
      addr     <= '0;
      is_write <= 1'b0;
      miso_q   <= 1'b0;
`ifdef SPI_SRAM_RDID_EN
      id_idx   <= '0;
`endif
    end else if (deselect || state == S_IDLE) begin
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (rise) begin
        rx_shift <= rx_next[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        case (state)
          S_CMD: begin
            is_write <= (rx_next == 8'h02);
`ifdef SPI_SRAM_RDID_EN
            if (rx_next == 8'h9F) begin
              tx_shift <= 8'hD5;
              id_idx   <= 2'd1;
            end
`endif
          end
          S_ADDR_HI: addr_hi <= rx_next;
          S_ADDR_LO: begin
            addr <= addr_full;
            if (!is_write) tx_shift <= mem_rdata;
          end
          S_READ: begin
            addr     <= addr_inc;
            tx_shift <= mem_rdata;
          end
          S_WRITE: addr <= addr_inc;
`ifdef SPI_SRAM_RDID_EN
          S_RDID: begin
            tx_shift <= id_byte;
            id_idx   <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
          end
`endif
          default: ;
        endcase
      end
      if (shifting && fall) begin
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end else if (!shifting) begin
        miso_q <= 1'b0;
      end
    end
  end

  // NOTE: memory contents survive reset, so the array sits in its own reset-free process.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= rx_next;
  end

  assign bus.spi_miso = miso_q;
  assign bus.active   = (state != S_IDLE);
endmodule

// File: tb/tb_spi_sram_target.sv
// Directed bench for spi_sram_target: write/read, wrap, aliasing, partial byte, ID read, reset.
module tb_spi_sram_target;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_sram_target_if bus ();

  spi_sram_target #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled just before the rising edge.
  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      bus.spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wr_frame(input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] rx;
    cs_low();
    spi_bits(8, 8'h02, rx);
    spi_bits(8, hi, rx);
    spi_bits(8, lo, rx);
    spi_bits(8, d0, rx);
    spi_bits(8, d1, rx);
    cs_high();
  endtask

  task automatic rd_frame(input logic [7:0] hi, input logic [7:0] lo,
                          output logic [7:0] d0, output logic [7:0] d1);
    logic [7:0] rx;
    cs_low();
    spi_bits(8, 8'h03, rx);
    spi_bits(8, hi, rx);
    spi_bits(8, lo, rx);
    spi_bits(8, 8'h00, d0);
    spi_bits(8, 8'h00, d1);
    cs_high();
  endtask

  initial begin
    logic [7:0] rx, d0, d1, d2;
    logic [7:0] id0, id1, id2;
`ifdef SPI_SRAM_RDID_EN
    id0 = 8'hD5; id1 = 8'hC0; id2 = 8'h06;
`else
    id0 = 8'h00; id1 = 8'h00; id2 = 8'h00;
`endif
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", {7'd0, bus.spi_miso}, 8'h00);
    check("reset_active", {7'd0, bus.active}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clock toggling while deselected must be ignored.
    spi_bits(8, 8'hFF, rx);
    check("idle_miso", rx, 8'h00);
    check("idle_active", {7'd0, bus.active}, 8'h00);

    // Write A5 3C at 0x0005, probing active and miso mid-frame.
    cs_low();
    check("frame_active", {7'd0, bus.active}, 8'h01);
    spi_bits(8, 8'h02, rx);
    check("wr_cmd_miso", rx, 8'h00);
    spi_bits(8, 8'h00, rx);
    spi_bits(8, 8'h05, rx);
    spi_bits(8, 8'hA5, rx);
    spi_bits(8, 8'h3C, rx);
    check("wr_data_miso", rx, 8'h00);
    cs_high();
    check("after_frame_active", {7'd0, bus.active}, 8'h00);

    rd_frame(8'h00, 8'h05, d0, d1);
    check("rd5_byte0", d0, 8'hA5);
    check("rd5_byte1", d1, 8'h3C);

    // Write across the top of the 64-byte array.
    wr_frame(8'h00, 8'h3F, 8'h11, 8'h22);
    rd_frame(8'h00, 8'h3F, d0, d1);
    check("wrap_byte0", d0, 8'h11);
    check("wrap_byte1", d1, 8'h22);
    rd_frame(8'h00, 8'h00, d0, d1);
    check("wrap_addr0", d0, 8'h22);

    rd_frame(8'h40, 8'h05, d0, d1);
    check("alias_byte0", d0, 8'hA5);
    check("alias_byte1", d1, 8'h3C);

    // Partial byte before deselect must not write.
    wr_frame(8'h00, 8'h07, 8'h55, 8'h66);
    cs_low();
    spi_bits(8, 8'h02, rx);
    spi_bits(8, 8'h00, rx);
    spi_bits(8, 8'h07, rx);
    spi_bits(5, 8'hFF, rx);
    cs_high();
    rd_frame(8'h00, 8'h07, d0, d1);
    check("partial_mem7", d0, 8'h55);
    check("partial_mem8", d1, 8'h66);
    rd_frame(8'h00, 8'h05, d0, d1);
    check("after_partial", d0, 8'hA5);

    // Unknown opcode: target stays selected but silent.
    cs_low();
    spi_bits(8, 8'h5A, rx);
    spi_bits(8, 8'h00, rx);
    check("ignore_miso", rx, 8'h00);
    check("ignore_active", {7'd0, bus.active}, 8'h01);
    cs_high();

    // ID read.
    cs_low();
    spi_bits(8, 8'h9F, rx);
    spi_bits(8, 8'h00, d0);
    spi_bits(8, 8'h00, d1);
    spi_bits(8, 8'h00, d2);
    check("rdid_byte0", d0, id0);
    check("rdid_byte1", d1, id1);
    check("rdid_byte2", d2, id2);
    spi_bits(8, 8'h00, d0);
    check("rdid_repeat", d0, id0);
    cs_high();

    // Reset mid-frame clears state but keeps memory.
    cs_low();
    spi_bits(8, 8'h03, rx);
    spi_bits(4, 8'h00, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_active", {7'd0, bus.active}, 8'h00);
    check("midreset_miso", {7'd0, bus.spi_miso}, 8'h00);
    bus.spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_frame(8'h00, 8'h05, d0, d1);
    check("mem_retained", d0, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
